simd_lane_serializer: RTL and testbench



---
 rtl/simd_pkg.sv | 19 +
 rtl/simd_lane_serializer.sv | 106 ++++++++++
 tb/tb_simd_lane_serializer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared FOUR12 SIMD slot layout for the vector-add and its serializer
package simd_pkg;

    localparam int P_W    = 48;
    localparam int SLOT_W = 12;
    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Extract slot idx (12 bits: 8-bit lane payload plus guard/carry bits) from a packed P word
    function automatic logic [SLOT_W-1:0] slot_of(input logic [P_W-1:0] word, input logic [1:0] idx);
        return word[idx*SLOT_W +: SLOT_W];
    endfunction

endpackage

// File: rtl/simd_lane_serializer.sv
// rtl/simd_lane_serializer.sv - packed FOUR12 P word to 8-bit lane stream; optional SIMD_LANE_CARRY_EN adds out_carry
module simd_lane_serializer
    import simd_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int SLOT_W = 12,
    parameter int LANE_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*SLOT_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         out_data,
    output logic [1:0]                out_lane,
`ifdef SIMD_LANE_CARRY_EN
    output logic                      out_carry,
`endif
    output logic                      out_last
);

    localparam logic [1:0] LAST_IDX = 2'(LANES - 1);

    state_t                    r_state;
    logic [1:0]                r_idx;
    logic [LANES*SLOT_W-1:0]   r_buf;

    state_t                    w_state_nxt;
    logic [1:0]                w_idx_nxt;
    logic [LANES*SLOT_W-1:0]   w_buf_nxt;
    logic [SLOT_W-1:0]         w_slot;
    logic                      w_is_last;

    assign w_slot    = slot_of(r_buf, r_idx);
    assign w_is_last = (r_idx == LAST_IDX);

`ifndef SIMD_LANE_CARRY_EN
    // Guard bits carry no meaning without the carry output
    logic w_unused_guard;
    assign w_unused_guard = ^w_slot[SLOT_W-1:LANE_W];
`endif

    // State, lane index and word buffer; reset drops any buffered word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // Next-state and handshake outputs; the last lane's transfer can reload the buffer with no bubble
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_buf_nxt   = r_buf;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_lane    = 2'd0;
        out_last    = 1'b0;
`ifdef SIMD_LANE_CARRY_EN
        out_carry   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_buf_nxt   = in_data;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_data  = w_slot[LANE_W-1:0];
                out_lane  = r_idx;
                out_last  = w_is_last;
`ifdef SIMD_LANE_CARRY_EN
                out_carry = |w_slot[SLOT_W-1:LANE_W];
`endif
                in_ready  = w_is_last && out_ready;
                if (out_ready) begin
                    if (!w_is_last) begin
                        w_idx_nxt = r_idx + 2'd1;
                    end else if (in_valid) begin
                        w_buf_nxt = in_data;
                        w_idx_nxt = 2'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simd_lane_serializer.sv
// tb/tb_simd_lane_serializer.sv - directed self-checking bench for simd_lane_serializer
module tb_simd_lane_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;
`ifdef SIMD_LANE_CARRY_EN
    logic        out_carry;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    simd_lane_serializer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
`ifdef SIMD_LANE_CARRY_EN
        .out_carry (out_carry),
`endif
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check one displayed lane against hand-computed values, then advance a cycle
    task automatic lane(input string tag, input logic [7:0] d, input logic [1:0] l, input logic ir);
        #1;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".lane"},  64'(out_lane),  64'(l));
        check({tag, ".last"},  64'(out_last),  64'(l == 2'd3));
        check({tag, ".ready"}, 64'(in_ready),  64'(ir));
        tick();
    endtask

    task automatic load(input logic [47:0] w);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        check("load.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.out_data",  64'(out_data),  64'd0);
        check("rst.out_lane",  64'(out_lane),  64'd0);
        check("rst.out_last",  64'(out_last),  64'd0);

        // Single word
        load(48'h080_0FF_00A_005);
        lane("w1l0", 8'h05, 2'd0, 1'b0);
        lane("w1l1", 8'h0A, 2'd1, 1'b0);
        lane("w1l2", 8'hFF, 2'd2, 1'b0);
        lane("w1l3", 8'h80, 2'd3, 1'b1);
        check("w1.idle", 64'(out_valid), 64'd0);

        // Back-to-back: second word held valid from the first lane onward
        load(48'h080_0FF_00A_005);
        in_valid = 1'b1;
        in_data  = 48'h004_003_002_001;
        lane("b2b0", 8'h05, 2'd0, 1'b0);
        lane("b2b1", 8'h0A, 2'd1, 1'b0);
        lane("b2b2", 8'hFF, 2'd2, 1'b0);
        lane("b2b3", 8'h80, 2'd3, 1'b1);
        in_valid = 1'b0;
        lane("b2b4", 8'h01, 2'd0, 1'b0);
        lane("b2b5", 8'h02, 2'd1, 1'b0);
        lane("b2b6", 8'h03, 2'd2, 1'b0);
        lane("b2b7", 8'h04, 2'd3, 1'b1);
        check("b2b.idle", 64'(out_valid), 64'd0);

        // Backpressure on lane 1, with a pending input word that must not be taken
        load(48'h080_0FF_00A_005);
        lane("bp0", 8'h05, 2'd0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h004_003_002_001;
        for (int i = 0; i < 3; i++) begin
            lane($sformatf("bp_stall%0d", i), 8'h0A, 2'd1, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        lane("bp1", 8'h0A, 2'd1, 1'b0);
        lane("bp2", 8'hFF, 2'd2, 1'b0);
        lane("bp3", 8'h80, 2'd3, 1'b1);
        check("bp.idle", 64'(out_valid), 64'd0);

        // Reset after lane 1 transfers
        load(48'h080_0FF_00A_005);
        lane("rm0", 8'h05, 2'd0, 1'b0);
        lane("rm1", 8'h0A, 2'd1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rm.out_valid", 64'(out_valid), 64'd0);
        check("rm.in_ready",  64'(in_ready),  64'd1);
        load(48'h0AA_0BB_0CC_0DD);
        lane("rm2", 8'hDD, 2'd0, 1'b0);
        lane("rm3", 8'hCC, 2'd1, 1'b0);
        lane("rm4", 8'hBB, 2'd2, 1'b0);
        lane("rm5", 8'hAA, 2'd3, 1'b1);

        // Guard bits: payload unaffected; carry flagged only on the overflowed lane
        load(48'h000_1FE_000_0FF);
`ifdef SIMD_LANE_CARRY_EN
        #1; check("cy0", 64'(out_carry), 64'd0);
`endif
        lane("cy.l0", 8'hFF, 2'd0, 1'b0);
`ifdef SIMD_LANE_CARRY_EN
        check("cy1", 64'(out_carry), 64'd0);
`endif
        lane("cy.l1", 8'h00, 2'd1, 1'b0);
`ifdef SIMD_LANE_CARRY_EN
        check("cy2", 64'(out_carry), 64'd1);
`endif
        lane("cy.l2", 8'hFE, 2'd2, 1'b0);
`ifdef SIMD_LANE_CARRY_EN
        check("cy3", 64'(out_carry), 64'd0);
`endif
        lane("cy.l3", 8'h00, 2'd3, 1'b1);
        check("cy.idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
